// File: rtl/adc_sample_filter.sv
// Boxcar averager over a 2^LOG2_DEPTH sample ring buffer, with a registered over-threshold flag.
// Define ADC_FILTER_HYST_EN to give the threshold flag a HYST-wide hysteresis band.
module adc_sample_filter #(
  parameter int unsigned LOG2_DEPTH = 3,
  parameter int unsigned HYST       = 4
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       clear,
  input  logic [7:0] threshold,
  output logic [7:0] avg_out,
  output logic       avg_valid,
  output logic       primed,
  output logic       over_thresh
);

  localparam int unsigned Depth = 1 << LOG2_DEPTH;
  localparam int unsigned SumW  = 8 + LOG2_DEPTH;

  if (LOG2_DEPTH < 1 || LOG2_DEPTH > 5 || HYST > 255) begin : g_bad_param
    $error("adc_sample_filter: LOG2_DEPTH must be 1..5 and HYST 0..255");
  end

  typedef enum logic {StFill, StRun} state_e;

  state_e                r_state, w_state_next;
  logic [7:0]            r_buf [Depth];
  logic [LOG2_DEPTH-1:0] r_wp;
  logic [SumW-1:0]       r_sum, w_sum_next;
  logic [SumW:0]         w_sum_ext;
  logic                  w_produce;
  logic [7:0]            w_avg;
  logic                  w_over_next;
  logic [7:0]            r_avg;
  logic                  r_valid;
  logic                  r_over;

  // During FILL the write pointer doubles as the fill count; it starts at 0 after reset/clear.
  always_comb begin
    w_state_next = r_state;
    w_produce    = 1'b0;
    w_sum_ext    = {1'b0, r_sum} + {{(LOG2_DEPTH + 1){1'b0}}, sample_in};
    if (r_state == StRun) begin
      w_sum_ext = w_sum_ext - {{(LOG2_DEPTH + 1){1'b0}}, r_buf[r_wp]};
    end
    unique case (r_state)
      StFill: begin
        if (sample_valid && (&r_wp)) begin
          w_state_next = StRun;
          w_produce    = 1'b1;
        end
      end
      StRun:   w_produce = sample_valid;
      default: w_state_next = StFill;
    endcase
    if (clear) begin
      w_state_next = StFill;
      w_produce    = 1'b0;
    end
    w_sum_next = w_sum_ext[SumW-1:0];
    w_avg      = w_sum_next[SumW-1:LOG2_DEPTH];
  end

`ifdef ADC_FILTER_HYST_EN
  localparam logic [7:0] HystW = 8'(HYST);
  logic [7:0] w_thr_lo;

  always_comb begin
    w_thr_lo    = (threshold > HystW) ? (threshold - HystW) : 8'd0;
    w_over_next = r_over;
    if (w_avg > threshold) begin
      w_over_next = 1'b1;
    end else if (w_avg < w_thr_lo) begin
      w_over_next = 1'b0;
    end
  end
`else
  always_comb begin
    w_over_next = (w_avg > threshold);
  end
`endif

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_sum <= '0;
      r_wp  <= '0;
    end else if (clear) begin
      r_sum <= '0;
      r_wp  <= '0;
    end else if (sample_valid) begin
      r_sum <= w_sum_next;
      r_wp  <= r_wp + 1'b1;
    end
  end

  // Stale entries are never subtracted during FILL, so the buffer needs no reset.
  always_ff @(posedge sclk) begin
    if (sample_valid && !clear) begin
      r_buf[r_wp] <= sample_in;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_avg   <= 8'd0;
      r_valid <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_valid <= w_produce;
      if (clear) begin
        r_avg  <= 8'd0;
        r_over <= 1'b0;
      end else if (w_produce) begin
        r_avg  <= w_avg;
        r_over <= w_over_next;
      end
    end
  end

  assign avg_out     = r_avg;
  assign avg_valid   = r_valid;
  assign over_thresh = r_over;
  assign primed      = (r_state == StRun);

endmodule

// File: tb/tb_adc_sample_filter.sv
// Self-checking bench for adc_sample_filter: window-queue reference model plus directed literals.
module tb_adc_sample_filter;

  localparam int unsigned L2D = 3;
  localparam int unsigned D   = 1 << L2D;
  localparam int unsigned HY  = 4;

  logic       sclk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] threshold = 8'h80;
  logic [7:0] avg_out;
  logic       avg_valid, primed, over_thresh;

  adc_sample_filter #(.LOG2_DEPTH(L2D), .HYST(HY)) dut (
    .sclk        (sclk),
    .rstn        (rstn),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .clear       (clear),
    .threshold   (threshold),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .primed      (primed),
    .over_thresh (over_thresh)
  );

  always #5 sclk = ~sclk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model: the last D accepted samples and the expected registered outputs.
  int         win[$];
  logic [7:0] exp_avg = 8'd0;
  logic       exp_valid = 1'b0, exp_primed = 1'b0, exp_over = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    win.delete();
    exp_avg = 8'd0; exp_valid = 1'b0; exp_primed = 1'b0; exp_over = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] s, input logic c,
                            input logic [7:0] thr);
    int sum;
    int lo;
    exp_valid = 1'b0;
    if (c) begin
      model_reset();
    end else if (v) begin
      win.push_back(int'(s));
      if (win.size() > D) void'(win.pop_front());
      if (win.size() == D) begin
        sum = 0;
        foreach (win[i]) sum += win[i];
        exp_avg    = 8'(sum / D);
        exp_valid  = 1'b1;
        exp_primed = 1'b1;
`ifdef ADC_FILTER_HYST_EN
        lo = (int'(thr) > HY) ? int'(thr) - HY : 0;
        if (int'(exp_avg) > int'(thr)) exp_over = 1'b1;
        else if (int'(exp_avg) < lo)   exp_over = 1'b0;
`else
        lo = 0;
        exp_over = (exp_avg > thr);
`endif
      end
    end
  endtask

  task automatic compare_all();
    chk("avg_valid", int'(avg_valid), int'(exp_valid));
    chk("primed", int'(primed), int'(exp_primed));
    chk("avg_out", int'(avg_out), int'(exp_avg));
    chk("over_thresh", int'(over_thresh), int'(exp_over));
    if (avg_valid) pulses++;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare 1 ns later.
  task automatic step(input logic v, input logic [7:0] s, input logic c);
    sample_valid = v; sample_in = s; clear = c;
    @(posedge sclk);
    model_step(v, s, c, threshold);
    #1;
    compare_all();
  endtask

  task automatic strobes(input int n, input logic [7:0] s);
    for (int i = 0; i < n; i++) step(1'b1, s, 1'b0);
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    sample_valid = 1'b0; clear = 1'b0;
    model_reset();
    #1;
    chk("rst avg_out", int'(avg_out), 0);
    chk("rst avg_valid", int'(avg_valid), 0);
    chk("rst primed", int'(primed), 0);
    chk("rst over_thresh", int'(over_thresh), 0);
    @(posedge sclk);
    #1 rstn = 1'b1;
  endtask

  int p0;

  initial begin
    #3;
    chk("reset avg_out", int'(avg_out), 0);
    chk("reset primed", int'(primed), 0);
    chk("reset avg_valid", int'(avg_valid), 0);
    chk("reset over_thresh", int'(over_thresh), 0);
    @(posedge sclk);
    #1 rstn = 1'b1;

    // Priming with 0x40
    p0 = pulses;
    strobes(7, 8'h40);
    chk("prime no pulse 1-7", pulses - p0, 0);
    step(1'b1, 8'h40, 1'b0);
    chk("prime avg", int'(avg_out), 'h40);
    chk("prime valid", int'(avg_valid), 1);
    chk("prime primed", int'(primed), 1);
    step(1'b0, 8'h00, 1'b0);
    chk("valid one cycle", int'(avg_valid), 0);

    // Running update
    step(1'b1, 8'hC0, 1'b0);
    chk("run avg 0x50", int'(avg_out), 'h50);

    // Wrap and width
    step(1'b0, 8'h00, 1'b1);
    p0 = pulses;
    strobes(16, 8'hFF);
    chk("wrap pulses", pulses - p0, 9);
    chk("wrap avg", int'(avg_out), 'hFF);

    // Threshold behaviour around 0x80
    threshold = 8'h80;
    step(1'b0, 8'h00, 1'b1);
    strobes(8, 8'h81);
    chk("thr 0x81 over", int'(over_thresh), 1);
    strobes(8, 8'h80);
    chk("thr avg 0x80", int'(avg_out), 'h80);
`ifdef ADC_FILTER_HYST_EN
    chk("thr 0x80 hold", int'(over_thresh), 1);
`else
    chk("thr 0x80 clear", int'(over_thresh), 0);
`endif
    strobes(8, 8'h7E);
`ifdef ADC_FILTER_HYST_EN
    chk("thr 0x7E hold", int'(over_thresh), 1);
`else
    chk("thr 0x7E clear", int'(over_thresh), 0);
`endif
    strobes(8, 8'h7B);
    chk("thr 0x7B clear", int'(over_thresh), 0);

    // clear beats sample_valid
    step(1'b1, 8'h55, 1'b1);
    chk("clear primed", int'(primed), 0);
    chk("clear avg", int'(avg_out), 0);
    p0 = pulses;
    strobes(7, 8'h10);
    chk("clear dropped sample", pulses - p0, 0);
    step(1'b1, 8'h10, 1'b0);
    chk("clear refill pulse", int'(avg_valid), 1);

    // Async reset mid-run and mid-fill
    strobes(3, 8'hF0);
    async_reset();
    strobes(5, 8'h22);
    async_reset();
    p0 = pulses;
    strobes(8, 8'h33);
    chk("post-reset pulses", pulses - p0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) threshold = 8'($urandom_range(8'h60, 8'hA0));
      if ($urandom_range(0, 3) == 0) sample_in = 8'($urandom);
      else sample_in = 8'($urandom_range(8'h60, 8'hA0));
      step(1'($urandom_range(0, 2) != 0), sample_in, 1'($urandom_range(0, 59) == 0));
      if (i == 700) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
